// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module  : vram_arbiter_if
// Brief   : Video / CPU / VRAM signal bundle seen by the VRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // Video scanout side
    logic              vid_req;
    logic [ADDR_W-1:0] vid_a;
    logic [DATA_W-1:0] vid_q;

    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_d;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_ack;

    // VRAM macro side
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    // Environment: scanout, CPU bus decoder and the VRAM macro
    modport master (
        output vid_req, vid_a, cpu_req, cpu_we, cpu_a, cpu_d, mem_q,
        input  vid_q, cpu_q, cpu_ack, mem_a, mem_d, mem_we
    );

    // Arbiter
    modport slave (
        input  vid_req, vid_a, cpu_req, cpu_we, cpu_a, cpu_d, mem_q,
        output vid_q, cpu_q, cpu_ack, mem_a, mem_d, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module  : vram_arbiter
// Brief   : Single-port VRAM arbiter; video reads always win, CPU gets idle slots.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vram_arbiter_if.slave      bus,
    output logic [STALL_W-1:0] stall_cnt_o
);

    localparam int                 c_STATE_W    = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RD_WAIT = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_ACK     = 2'd2;

    logic [c_STATE_W-1:0] state_q, state_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]    cpu_q_q, cpu_q_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [ADDR_W-1:0]    w_mem_a;
    logic                 w_mem_we;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= c_ST_IDLE;
            cpu_ack_q <= 1'b0;
            cpu_q_q   <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cpu_ack_q <= cpu_ack_d;
            cpu_q_q   <= cpu_q_d;
            stall_q   <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: new CPU requests are accepted only from IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.cpu_req && !bus.vid_req) begin
                    state_d = bus.cpu_we ? c_ST_ACK : c_ST_RD_WAIT;
                end
            end
            c_ST_RD_WAIT: state_d = c_ST_ACK;
            c_ST_ACK:     state_d = c_ST_IDLE;
            default:      state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_a   = bus.vid_a;
        w_mem_we  = 1'b0;
        cpu_ack_d = 1'b0;
        cpu_q_d   = cpu_q_q;
        stall_d   = stall_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.cpu_req) begin
                    if (!bus.vid_req) begin
                        w_mem_a   = bus.cpu_a;
                        w_mem_we  = bus.cpu_we & ~rst_i;
                        cpu_ack_d = bus.cpu_we;
                    end else if (stall_q != {STALL_W{1'b1}}) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
            end
            // mem_q now carries the word addressed last cycle, whatever video does now
            c_ST_RD_WAIT: begin
                cpu_q_d   = bus.mem_q;
                cpu_ack_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_a   = w_mem_a;
    assign bus.mem_we  = w_mem_we;
    assign bus.mem_d   = bus.cpu_d;
    assign bus.vid_q   = bus.mem_q;
    assign bus.cpu_q   = cpu_q_q;
    assign bus.cpu_ack = cpu_ack_q;
    assign stall_cnt_o = stall_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_video_never_blocked : assert property (
        @(posedge clk_i) disable iff (rst_i) !(bus.vid_req && w_mem_we));

    a_ack_single_pulse : assert property (
        @(posedge clk_i) disable iff (rst_i) cpu_ack_q |=> !cpu_ack_q);

    a_ack_only_in_ack : assert property (
        @(posedge clk_i) disable iff (rst_i) cpu_ack_q |-> (state_q == c_ST_ACK));

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module  : tb_vram_arbiter
// Brief   : Directed scoreboard bench for vram_arbiter with a synchronous VRAM model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int STALL_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [STALL_W-1:0] stall_cnt;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port VRAM, read-before-write, 1-cycle read latency
    logic [DATA_W-1:0] vram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) vram[bus.mem_a] <= bus.mem_d;
        bus.mem_q <= vram[bus.mem_a];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  sb [$];
    logic [7:0]  mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.cpu_ack === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack: got ack=1 expected no pending access");
            end else begin
                mon_exp = sb.pop_front();
                if (bus.cpu_q !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_cpu_q: got 0x%0h expected 0x%0h", bus.cpu_q, mon_exp);
                end
            end
        end
    end

    // One CPU access; vmask bit k drives vid_req in cycle k after the request appears
    task automatic cpu_op(input string name, input logic we, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp_q,
                          input logic [7:0] vmask, input logic [15:0] va,
                          input logic [7:0] exp_vid, output int lat, output int we_cnt);
        int  k;
        bit  done;
        sb.push_back(exp_q);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_a = a; bus.cpu_d = d;
        bus.vid_a   = va;   bus.vid_req = vmask[0];
        k = 0; we_cnt = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (k > 0 && k <= 8 && vmask[k-1]) check({name, "_vid_q"}, 32'(bus.vid_q), 32'(exp_vid));
            if (bus.cpu_ack) begin
                done = 1'b1;
            end else begin
                k++;
                if (k >= 20) begin
                    check({name, "_ack_timeout"}, 32'(bus.cpu_ack), 32'd1);
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    bus.vid_req = (k < 8) ? vmask[k] : 1'b0;
                end
            end
        end
        lat = k;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        @(negedge clk);
        check({name, "_ack_single"}, 32'(bus.cpu_ack), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, wc, acks;
        for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
        bus.vid_req = 1'b0; bus.vid_a = '0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h9000; bus.cpu_d = 8'hEE;

        // Reset: write request present but must not reach the VRAM
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_cpu_q",   32'(bus.cpu_q),   32'd0);
        check("rst_stall",   32'(stall_cnt),   32'd0);
        check("rst_mem_we",  32'(bus.mem_we),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        @(negedge clk);
        check("rst_no_write", 32'(vram[16'h9000]), 32'h00);

        // T1: idle-bus write
        cpu_op("t1", 1'b1, 16'h8000, 8'h41, 8'h00, 8'h00, 16'h0000, 8'h00, lat, wc);
        check("t1_lat", 32'(lat), 32'd1);
        check("t1_we_cnt", 32'(wc), 32'd1);
        check("t1_vram", 32'(vram[16'h8000]), 32'h41);
        cpu_op("prep", 1'b1, 16'h8002, 8'h07, 8'h00, 8'h00, 16'h0000, 8'h00, lat, wc);
        check("prep_lat", 32'(lat), 32'd1);

        // T2: idle-bus read
        cpu_op("t2", 1'b0, 16'h8000, 8'h00, 8'h41, 8'h00, 16'h0000, 8'h00, lat, wc);
        check("t2_lat", 32'(lat), 32'd2);
        check("t2_we_cnt", 32'(wc), 32'd0);
        check("t2_stall", 32'(stall_cnt), 32'd0);

        // T3: video holds the bus for two cycles
        cpu_op("t3", 1'b1, 16'h8001, 8'h55, 8'h41, 8'h03, 16'h8000, 8'h41, lat, wc);
        check("t3_lat", 32'(lat), 32'd3);
        check("t3_we_cnt", 32'(wc), 32'd1);
        check("t3_stall", 32'(stall_cnt), 32'd2);
        check("t3_vram", 32'(vram[16'h8001]), 32'h55);

        // T4: video read lands in RD_WAIT
        cpu_op("t4", 1'b0, 16'h8001, 8'h00, 8'h55, 8'h02, 16'h8002, 8'h07, lat, wc);
        check("t4_lat", 32'(lat), 32'd2);
        check("t4_stall", 32'(stall_cnt), 32'd2);

        // T5: back-to-back writes with cpu_req held high
        sb.push_back(8'h55); sb.push_back(8'h55);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h8010; bus.cpu_d = 8'hA1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t5_we_c%0d", c),  32'(bus.mem_we),  32'((c % 2) == 0));
            check($sformatf("t5_ack_c%0d", c), 32'(bus.cpu_ack), 32'((c % 2) == 1));
            if (c == 2) check("t5_mem_a2", 32'(bus.mem_a), 32'h8011);
            @(posedge clk); #1;
            if (c == 1) begin bus.cpu_a = 16'h8011; bus.cpu_d = 8'hB2; end
            if (c == 3) bus.cpu_req = 1'b0;
        end
        @(negedge clk);
        check("t5_ack_end", 32'(bus.cpu_ack), 32'd0);
        check("t5_vram0", 32'(vram[16'h8010]), 32'hA1);
        check("t5_vram1", 32'(vram[16'h8011]), 32'hB2);

        // T6: reset while in RD_WAIT; the pending ack must vanish
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h8000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_ack", 32'(bus.cpu_ack), 32'd0);
        check("t6_stall", 32'(stall_cnt), 32'd0);
        check("t6_cpu_q", 32'(bus.cpu_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_req = 1'b0;
        cpu_op("t6r", 1'b0, 16'h8000, 8'h00, 8'h41, 8'h00, 16'h0000, 8'h00, lat, wc);
        check("t6r_lat", 32'(lat), 32'd2);

        // T7: continuous video starves the CPU; counter saturates
        sb.push_back(8'h41);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h8020; bus.cpu_d = 8'hC3;
        bus.vid_req = 1'b1; bus.vid_a = 16'h8000;
        wc = 0; acks = 0;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (bus.mem_we) wc++;
            if (bus.cpu_ack) acks++;
            if (k == 65534) check("t7_stall_fffe", 32'(stall_cnt), 32'hFFFE);
            if (k == 65535) check("t7_stall_ffff", 32'(stall_cnt), 32'hFFFF);
            if (k == 69999) check("t7_stall_hold", 32'(stall_cnt), 32'hFFFF);
            @(posedge clk); #1;
            if (k == 69999) bus.vid_req = 1'b0;
        end
        check("t7_no_we", 32'(wc), 32'd0);
        check("t7_no_ack", 32'(acks), 32'd0);
        @(negedge clk);
        check("t7_issue_we", 32'(bus.mem_we), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t7_ack", 32'(bus.cpu_ack), 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("t7_vram", 32'(vram[16'h8020]), 32'hC3);
        check("t7_stall_end", 32'(stall_cnt), 32'hFFFF);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
